// File: rtl/speed_sched.sv
// Purpose: run-state controller for the game tick timer; sequences start/pause/resume/game over and speeds up per level.
// Latency: every output is registered; Step follows its accepted TmrTick by exactly one Clk cycle.
// Backpressure: none; all inputs are one-cycle pulses, and pulses that the current state does not use are dropped.
module speed_sched #(
    parameter logic [9:0] INIT_PERIOD     = 10'd499,
    parameter logic [9:0] MIN_PERIOD      = 10'd99,
    parameter logic [9:0] STEP_DEC        = 10'd50,
    parameter logic [7:0] TICKS_PER_LEVEL = 8'd32,
    parameter logic [2:0] MAX_LEVEL       = 3'd7
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       Start,
    input  logic       Pause,
    input  logic       Collision,
    input  logic       TmrTick,
    output logic       TmrEnable,
    output logic       TmrClear,
    output logic [9:0] TmrCfg,
    output logic       Step,
    output logic [2:0] Level,
    output logic       Running,
    output logic       GameOver
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_PAUSE = 2'd2;
    localparam logic [1:0] ST_OVER  = 2'd3;

    logic [1:0]  state;
    logic [7:0]  tick_cnt;
    logic [10:0] cfg_floor;
    logic [9:0]  cfg_next;
    logic [2:0]  level_next;
    logic        last_tick;

    // Threshold widened to 11 bits so MIN_PERIOD+STEP_DEC cannot wrap.
    assign cfg_floor = {1'b0, MIN_PERIOD} + {1'b0, STEP_DEC};
    assign last_tick = (tick_cnt == TICKS_PER_LEVEL - 8'd1);

    // Next period and level taken on a level-up: clamp the period, saturate the level.
    always_comb begin
        cfg_next   = TmrCfg - STEP_DEC;
        level_next = Level + 3'd1;
        if ({1'b0, TmrCfg} < cfg_floor) begin
            cfg_next = MIN_PERIOD;
        end
        if (Level >= MAX_LEVEL) begin
            level_next = MAX_LEVEL;
        end
    end

    // Run-state sequencing with priority Collision > Start > Pause > TmrTick.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state     <= ST_IDLE;
            tick_cnt  <= 8'd0;
            TmrEnable <= 1'b0;
            TmrClear  <= 1'b1;
            TmrCfg    <= INIT_PERIOD;
            Step      <= 1'b0;
            Level     <= 3'd0;
            Running   <= 1'b0;
            GameOver  <= 1'b0;
        end else if (Collision && (state == ST_RUN || state == ST_PAUSE)) begin
            // Game over: stop and clear the timer, keep Level/TmrCfg for display.
            state     <= ST_OVER;
            TmrEnable <= 1'b0;
            TmrClear  <= 1'b1;
            Step      <= 1'b0;
            Running   <= 1'b0;
            GameOver  <= 1'b1;
        end else if (Start && (state == ST_IDLE || state == ST_OVER)) begin
            // New game: reload the initial period and release the timer.
            state     <= ST_RUN;
            tick_cnt  <= 8'd0;
            TmrEnable <= 1'b1;
            TmrClear  <= 1'b0;
            TmrCfg    <= INIT_PERIOD;
            Step      <= 1'b0;
            Level     <= 3'd0;
            Running   <= 1'b1;
            GameOver  <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    Step     <= TmrTick;
                    TmrClear <= 1'b0;
                    if (TmrTick) begin
                        if (last_tick) begin
                            // Level-up: restart the timer count so the new period starts from zero.
                            tick_cnt <= 8'd0;
                            Level    <= level_next;
                            TmrCfg   <= cfg_next;
                            TmrClear <= 1'b1;
                        end else begin
                            tick_cnt <= tick_cnt + 8'd1;
                        end
                    end
                    // A tick in the same cycle as Pause is still counted above.
                    if (Pause) begin
                        state     <= ST_PAUSE;
                        TmrEnable <= 1'b0;
                        Running   <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    // Timer holds its partial count: disabled, not cleared.
                    Step     <= 1'b0;
                    TmrClear <= 1'b0;
                    if (Pause) begin
                        state     <= ST_RUN;
                        TmrEnable <= 1'b1;
                        Running   <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    Step      <= 1'b0;
                    TmrEnable <= 1'b0;
                    TmrClear  <= 1'b1;
                end
                default: begin
                    Step <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_speed_sched.sv
// Purpose: self-checking bench for speed_sched with small parameters so level-ups and the clamp are reached quickly.
// Latency: inputs change on the falling edge, outputs are compared on the following falling edges.
// Backpressure: none; the bench only issues one-cycle pulses.
module tb_speed_sched;

    localparam int P_INIT = 10;
    localparam int P_MIN  = 3;
    localparam int P_DEC  = 4;
    localparam int P_TPL  = 4;
    localparam int P_MAX  = 2;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_OVER  = 3;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       Start = 1'b0;
    logic       Pause = 1'b0;
    logic       Collision = 1'b0;
    logic       TmrTick = 1'b0;
    logic       TmrEnable;
    logic       TmrClear;
    logic [9:0] TmrCfg;
    logic       Step;
    logic [2:0] Level;
    logic       Running;
    logic       GameOver;

    int checks = 0;
    int failures = 0;
    int step_seen = 0;
    int s0;
    int s1;

    // Reference model state
    int m_mode  = M_IDLE;
    int m_cfg   = P_INIT;
    int m_level = 0;
    int m_tick  = 0;
    bit m_step  = 1'b0;
    bit m_lvlup = 1'b0;

    speed_sched #(
        .INIT_PERIOD(10'd10),
        .MIN_PERIOD(10'd3),
        .STEP_DEC(10'd4),
        .TICKS_PER_LEVEL(8'd4),
        .MAX_LEVEL(3'd2)
    ) dut (
        .Clk(Clk),
        .Rst(Rst),
        .Start(Start),
        .Pause(Pause),
        .Collision(Collision),
        .TmrTick(TmrTick),
        .TmrEnable(TmrEnable),
        .TmrClear(TmrClear),
        .TmrCfg(TmrCfg),
        .Step(Step),
        .Level(Level),
        .Running(Running),
        .GameOver(GameOver)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Game rules: which mode we are in, how many ticks were taken, and the period after each level.
    always @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            m_mode  = M_IDLE;
            m_cfg   = P_INIT;
            m_level = 0;
            m_tick  = 0;
            m_step  = 1'b0;
            m_lvlup = 1'b0;
        end else begin
            m_step  = 1'b0;
            m_lvlup = 1'b0;
            if (Collision && (m_mode == M_RUN || m_mode == M_PAUSE)) begin
                m_mode = M_OVER;
            end else if (Start && (m_mode == M_IDLE || m_mode == M_OVER)) begin
                m_mode  = M_RUN;
                m_cfg   = P_INIT;
                m_level = 0;
                m_tick  = 0;
            end else if (m_mode == M_RUN) begin
                if (TmrTick) begin
                    m_step = 1'b1;
                    m_tick = m_tick + 1;
                    if (m_tick == P_TPL) begin
                        m_tick  = 0;
                        m_lvlup = 1'b1;
                        m_level = (m_level + 1 > P_MAX) ? P_MAX : m_level + 1;
                        m_cfg   = (m_cfg < P_MIN + P_DEC) ? P_MIN : m_cfg - P_DEC;
                    end
                end
                if (Pause) m_mode = M_PAUSE;
            end else if (m_mode == M_PAUSE && Pause) begin
                m_mode = M_RUN;
            end
        end
    end

    // Every cycle: outputs must follow the model's mode, level, period and strobes.
    always @(negedge Clk) begin
        chk("cmp_enable", int'(TmrEnable), int'(m_mode == M_RUN));
        chk("cmp_running", int'(Running), int'(m_mode == M_RUN));
        chk("cmp_gameover", int'(GameOver), int'(m_mode == M_OVER));
        chk("cmp_clear", int'(TmrClear), int'(m_mode == M_IDLE || m_mode == M_OVER || m_lvlup));
        chk("cmp_step", int'(Step), int'(m_step));
        chk("cmp_level", int'(Level), m_level);
        chk("cmp_cfg", int'(TmrCfg), m_cfg);
        if (Step) step_seen++;
    end

    task automatic drive(input logic s, input logic p, input logic c, input logic t);
        @(negedge Clk);
        Start = s;
        Pause = p;
        Collision = c;
        TmrTick = t;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick_once();
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle();
    endtask

    initial begin
        #1 Rst = 1'b1;
        repeat (2) @(negedge Clk);
        chk("rst_cfg", int'(TmrCfg), 10);
        chk("rst_clear", int'(TmrClear), 1);
        chk("rst_enable", int'(TmrEnable), 0);
        chk("rst_level", int'(Level), 0);
        chk("rst_step", int'(Step), 0);
        chk("rst_running", int'(Running), 0);
        chk("rst_gameover", int'(GameOver), 0);
        Rst = 1'b0;
        idle();
        idle();
        chk("idle_enable", int'(TmrEnable), 0);

        // 1. Start
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("start_cfg", int'(TmrCfg), 10);
        chk("start_level", int'(Level), 0);
        chk("start_enable", int'(TmrEnable), 1);
        chk("start_clear", int'(TmrClear), 0);
        chk("start_running", int'(Running), 1);

        // 2. Twelve ticks, three level-ups, clamp and saturation
        s0 = step_seen;
        for (int i = 1; i <= 12; i++) begin
            tick_once();
            chk("t2_step", int'(Step), 1);
            if (i == 4) begin
                chk("t2_lvl1", int'(Level), 1);
                chk("t2_cfg6", int'(TmrCfg), 6);
                chk("t2_clear_pulse", int'(TmrClear), 1);
            end
            if (i == 8) begin
                chk("t2_lvl2", int'(Level), 2);
                chk("t2_cfg3", int'(TmrCfg), 3);
            end
            if (i == 12) begin
                chk("t2_lvl_sat", int'(Level), 2);
                chk("t2_cfg_sat", int'(TmrCfg), 3);
            end
        end
        idle();
        chk("t2_clear_drop", int'(TmrClear), 0);
        idle();
        chk("t2_step_count", step_seen - s0, 12);

        // 4. Collision together with a tick
        tick_once();
        drive(1'b0, 1'b0, 1'b1, 1'b1);
        idle();
        chk("t4_step", int'(Step), 0);
        chk("t4_gameover", int'(GameOver), 1);
        chk("t4_enable", int'(TmrEnable), 0);
        chk("t4_clear", int'(TmrClear), 1);
        chk("t4_level_held", int'(Level), 2);
        chk("t4_cfg_held", int'(TmrCfg), 3);
        chk("t4_tickcnt_model", m_tick, 1);
        tick_once();
        chk("t4_over_tick", int'(Step), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("t4_over_pause", int'(GameOver), 1);
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("t4_restart_cfg", int'(TmrCfg), 10);
        chk("t4_restart_level", int'(Level), 0);
        chk("t4_restart_go", int'(GameOver), 0);

        // 3. Pause after two ticks, ticks ignored while paused, resume
        tick_once();
        tick_once();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("t3_pause_enable", int'(TmrEnable), 0);
        chk("t3_pause_clear", int'(TmrClear), 0);
        chk("t3_pause_running", int'(Running), 0);
        s1 = step_seen;
        for (int i = 0; i < 3; i++) begin
            tick_once();
            chk("t3_paused_step", int'(Step), 0);
            chk("t3_paused_clear", int'(TmrClear), 0);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        chk("t3_resume_enable", int'(TmrEnable), 1);
        chk("t3_paused_steps", step_seen - s1, 0);
        tick_once();
        chk("t3_no_lvl_yet", int'(Level), 0);
        tick_once();
        chk("t3_lvl1", int'(Level), 1);
        chk("t3_cfg6", int'(TmrCfg), 6);
        chk("t3_clear_pulse", int'(TmrClear), 1);

        // 5. Pause and tick in the same cycle
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        idle();
        chk("t5_step", int'(Step), 1);
        chk("t5_running", int'(Running), 0);
        chk("t5_enable", int'(TmrEnable), 0);
        idle();
        chk("t5_step_once", int'(Step), 0);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        idle();
        tick_once();
        tick_once();
        chk("t5_not_yet", int'(Level), 1);
        tick_once();
        chk("t5_counted_lvl", int'(Level), 2);
        chk("t5_counted_cfg", int'(TmrCfg), 3);

        // 6. Asynchronous reset mid-game at level 1
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        for (int i = 0; i < 4; i++) tick_once();
        chk("t6_pre_level", int'(Level), 1);
        chk("t6_pre_cfg", int'(TmrCfg), 6);
        #2 Rst = 1'b1;
        #1;
        chk("t6_async_cfg", int'(TmrCfg), 10);
        chk("t6_async_clear", int'(TmrClear), 1);
        chk("t6_async_enable", int'(TmrEnable), 0);
        chk("t6_async_level", int'(Level), 0);
        chk("t6_async_running", int'(Running), 0);
        @(negedge Clk);
        Rst = 1'b0;
        idle();
        idle();
        chk("t6_after_idle", int'(TmrEnable), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
